// File: rtl/demux_frame_pkg.sv
// rtl/demux_frame_pkg.sv - shared types and constants for the demux frame controller
package demux_frame_pkg;

  localparam int ADDR_BITS = 2;
  localparam int NUM_CH    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    PAYLOAD,
    PARITY
  } frame_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - up-counter with clear, enable and terminal-count flag
module frame_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/demux_frame_ctrl.sv
// rtl/demux_frame_ctrl.sv - serial frame parser driving a 1:4 demux select and data bit
// Optional even-parity check and frame_err are built only when PARITY_EN is defined.
module demux_frame_ctrl
  import demux_frame_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  input  logic                 rx_valid,
  output logic                 demux_in,
  output logic [ADDR_BITS-1:0] demux_sel,
  output logic                 demux_valid,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
  localparam int SEL_W = $clog2(NUM_CH);

  frame_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 in_q, in_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]     cnt_term;
`ifdef PARITY_EN
  logic                 par_q, par_d;
  logic                 err_q, err_d;
`endif

  frame_bit_counter #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    in_d     = 1'b0;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = (state_q == ADDR) ? CNT_W'(ADDR_BITS - 1) : CNT_W'(PAYLOAD_LEN - 1);
`ifdef PARITY_EN
    par_d    = par_q;
    err_d    = 1'b0;
`endif
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_bit) begin
            state_d = ADDR;
            busy_d  = 1'b1;
            cnt_clr = 1'b1;
`ifdef PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
        ADDR: begin
          // addr[0] arrives first, so shift in from the top
          addr_d = {rx_bit, addr_q[ADDR_BITS-1:1]};
`ifdef PARITY_EN
          par_d  = par_q ^ rx_bit;
`endif
          if (cnt_tc) begin
            sel_d   = addr_d;
            state_d = PAYLOAD;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        PAYLOAD: begin
          in_d    = rx_bit;
          valid_d = 1'b1;
`ifdef PARITY_EN
          par_d   = par_q ^ rx_bit;
`endif
          if (cnt_tc) begin
            cnt_clr = 1'b1;
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_en = 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = par_q ^ rx_bit;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      in_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      in_q    <= in_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  assign demux_in    = in_q;
  assign demux_sel   = sel_q;
  assign demux_valid = valid_q;
  assign frame_busy  = busy_q;
  assign frame_done  = done_q;
`ifdef PARITY_EN
  assign frame_err   = err_q;
`else
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// tb/tb_demux_frame_ctrl.sv - self-checking bench for demux_frame_ctrl (PARITY_EN aware)
module tb_demux_frame_ctrl;

  localparam int PL = 8;
`ifdef PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FLEN = 3 + PL + PAR_EN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_bit = 1'b0;
  logic       rx_valid = 1'b0;
  logic       demux_in;
  logic [1:0] demux_sel;
  logic       demux_valid;
  logic       frame_busy;
  logic       frame_done;
  logic       frame_err;

  int tests = 0;
  int fails = 0;

  demux_frame_ctrl #(.PAYLOAD_LEN(PL)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .demux_in    (demux_in),
    .demux_sel   (demux_sel),
    .demux_valid (demux_valid),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-position model: outputs follow from the index of each accepted bit in the frame.
  int         m_pos = 0;
  int         m_ones = 0;
  logic [1:0] m_addr = 2'b00;
  logic       e_in = 1'b0, e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [1:0] e_sel = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_ones = 0; m_addr = 2'b00;
      e_in = 0; e_valid = 0; e_busy = 0; e_done = 0; e_err = 0; e_sel = 2'b00;
    end else begin
      e_in = 0; e_valid = 0; e_done = 0; e_err = 0;
      if (rx_valid) begin
        if (m_pos == 0) begin
          if (rx_bit) begin
            m_pos = 1; m_ones = 0; e_busy = 1;
          end
        end else begin
          if (m_pos == 1) m_addr[0] = rx_bit;
          if (m_pos == 2) begin
            m_addr[1] = rx_bit;
            e_sel = m_addr;
          end
          if (m_pos >= 3 && m_pos < 3 + PL) begin
            e_valid = 1; e_in = rx_bit;
          end
          m_ones += int'(rx_bit);
          m_pos++;
          if (m_pos == FLEN) begin
            m_pos = 0; e_busy = 0; e_done = 1;
            e_err = (PAR_EN == 1) && m_ones[0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("demux_in",    32'(demux_in),    32'(e_in));
      check("demux_valid", 32'(demux_valid), 32'(e_valid));
      check("demux_sel",   32'(demux_sel),   32'(e_sel));
      check("frame_busy",  32'(frame_busy),  32'(e_busy));
      check("frame_done",  32'(frame_done),  32'(e_done));
      check("frame_err",   32'(frame_err),   32'(e_err));
    end
  end

  // Capture of what the DUT actually delivered, for hand-computed literal checks.
  logic [7:0] cap_byte = 8'h00;
  int         cap_n = 0;
  logic [1:0] cap_sel = 2'b00;
  int         done_n = 0;
  logic       done_w_valid = 1'b0;
  logic       last_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (demux_valid) begin
        cap_byte = {cap_byte[6:0], demux_in};
        cap_n++;
        cap_sel = demux_sel;
      end
      if (frame_done) begin
        done_n++;
        done_w_valid = demux_valid;
        last_err = frame_err;
      end
    end
  end

  task automatic clear_cap();
    cap_byte = 8'h00; cap_n = 0; cap_sel = 2'b00; done_n = 0; done_w_valid = 0; last_err = 0;
  endtask

  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    rx_valid = v;
    rx_bit   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [7:0] data,
                            input bit stall, input bit flip);
    logic [11:0] bits;
    int          n;
    bits = {1'b1, ch[0], ch[1], data, (^{ch, data}) ^ flip};
    n    = FLEN;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, bits[11-i]);
      if (stall) drive(1'b0, ~bits[11-i]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_demux_in",    32'(demux_in),    32'd0);
    check("rst_demux_sel",   32'(demux_sel),   32'd0);
    check("rst_demux_valid", 32'(demux_valid), 32'd0);
    check("rst_frame_busy",  32'(frame_busy),  32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    check("rst_frame_err",   32'(frame_err),   32'd0);
    rst = 1'b0;

    repeat (10) drive(1'b1, 1'b0);
    idle(1);
    check("noise_busy", 32'(frame_busy), 32'd0);
    check("noise_sel",  32'(demux_sel),  32'd0);

    clear_cap();
    send_frame(2'd2, 8'hB3, 1'b0, 1'b0);
    idle(3);
    check("ch2_bits",  32'(cap_byte), 32'hB3);
    check("ch2_count", 32'(cap_n),    32'd8);
    check("ch2_sel",   32'(cap_sel),  32'd2);
    check("ch2_done",  32'(done_n),   32'd1);
    check("ch2_done_with_last", 32'(done_w_valid), 32'(PAR_EN == 0));

    clear_cap();
    send_frame(2'd2, 8'hB3, 1'b1, 1'b0);
    idle(3);
    check("stall_bits",  32'(cap_byte), 32'hB3);
    check("stall_count", 32'(cap_n),    32'd8);
    check("stall_done",  32'(done_n),   32'd1);

    clear_cap();
    send_frame(2'd3, 8'h5A, 1'b0, 1'b0);
    send_frame(2'd1, 8'hC3, 1'b0, 1'b0);
    idle(3);
    check("b2b_count", 32'(cap_n),     32'd16);
    check("b2b_done",  32'(done_n),    32'd2);
    check("b2b_last",  32'(cap_byte),  32'hC3);
    check("b2b_sel",   32'(demux_sel), 32'd1);

`ifdef PARITY_EN
    clear_cap();
    send_frame(2'd1, 8'h01, 1'b0, 1'b0);
    idle(2);
    check("par_ok_done", 32'(done_n),   32'd1);
    check("par_ok_err",  32'(last_err), 32'd0);
    clear_cap();
    send_frame(2'd1, 8'h01, 1'b0, 1'b1);
    idle(2);
    check("par_bad_done", 32'(done_n),   32'd1);
    check("par_bad_err",  32'(last_err), 32'd1);
`endif

    clear_cap();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_demux_in",    32'(demux_in),    32'd0);
    check("arst_demux_sel",   32'(demux_sel),   32'd0);
    check("arst_demux_valid", 32'(demux_valid), 32'd0);
    check("arst_frame_busy",  32'(frame_busy),  32'd0);
    check("arst_frame_done",  32'(frame_done),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("arst_no_done", 32'(done_n), 32'd0);
    clear_cap();
    send_frame(2'd1, 8'h96, 1'b0, 1'b0);
    idle(3);
    check("post_rst_bits", 32'(cap_byte), 32'h96);
    check("post_rst_sel",  32'(cap_sel),  32'd1);
    check("post_rst_done", 32'(done_n),   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
